uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Consumes the byte stream from the UART receiver and assembles fixed 6-byte command frames
//  for the TDC control logic: SYNC, CMD, ADDR, DATA_HI, DATA_LO, CSUM.
//  A frame with a valid checksum produces a one-cycle cmd_valid strobe with registered fields.
//  Frames with a bad checksum or an inter-byte gap raise frame_err and are discarded.
// PARAMETERS
//  SYNC_BYTE    8'hA5   frame start marker
//  TIMEOUT_CYC  50000   max clk cycles between accepted bytes inside a frame
//  TO_W         16      width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  din_byte      in   8   received byte, stable while din_byte_rdy is high
//  din_byte_rdy  in   1   byte-ready level from the UART receiver; may stay high for several clk cycles
//  cmd_valid     out  1   one-clk pulse, good frame decoded
//  cmd_code      out  8   CMD field of the last good frame
//  cmd_addr      out  8   ADDR field of the last good frame
//  cmd_data      out  16  {DATA_HI,DATA_LO} of the last good frame
//  frame_err     out  1   one-clk pulse on checksum error or timeout
//  busy          out  1   high while state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; csum accumulator 0; timeout counter 0; rdy edge register 0.
//  - Byte accept: a byte is accepted on the rising edge of din_byte_rdy, i.e. the first clk cycle
//    with din_byte_rdy=1 after a cycle with din_byte_rdy=0 (edge register). Exactly one accept
//    per high period, regardless of how long the level is held.
//  - FSM, advancing only on accept (except timeout):
//    IDLE -> CMD  when byte==SYNC_BYTE; all other bytes are ignored, no error
//    CMD  -> ADDR  latch cmd_r, csum=byte
//    ADDR -> DHI   latch addr_r, csum^=byte
//    DHI  -> DLO   latch dhi_r, csum^=byte
//    DLO  -> CSUM  latch dlo_r, csum^=byte
//    CSUM -> IDLE  if byte==csum: load outputs, cmd_valid=1 for the next clk; else frame_err=1
//  - SYNC_BYTE received in a non-IDLE state is treated as data; there is no resync.
//  - Latency: cmd_valid and the updated cmd_* fields appear one clk after the CSUM byte is accepted.
//  - cmd_code/addr/data hold their value until the next good frame; a bad frame leaves them untouched.
//  - Timeout: the counter clears on every accept and in IDLE, and increments otherwise.
//    When it reaches TIMEOUT_CYC: frame_err pulses, FSM returns to IDLE, and partial fields are dropped.
//  - Simultaneous accept and timeout in the same cycle: the accept wins; the counter clears and the
//    byte is processed.
//  - cmd_valid and frame_err are never high in the same cycle.
//  - Reset mid-frame: immediate return to IDLE with no pulse; the next frame must start with SYNC.
//  - csum is an 8-bit XOR of CMD..DATA_LO; the SYNC byte is excluded.
// STRUCTURE
//  - Shared include uart_cmd_defs.vh holds:
//    * FSM state encodings (3-bit: IDLE=0, CMD=1, ADDR=2, DHI=3, DLO=4, CSUM=5)
//    * default SYNC_BYTE
//    * command code constants used by the TDC register block
//  - One sub-module, frame_timeout: TO_W counter with clear, enable and hit output, parameterised
//    by TIMEOUT_CYC.
//  - Parser core = edge register + FSM + field registers + XOR accumulator, all in this file.
// TESTING
//  1. Good frame A5 01 10 12 34 37 -> one cmd_valid pulse; cmd_code=01, cmd_addr=10,
//     cmd_data=1234; frame_err stays 0.
//  2. Same frame with CSUM=36 -> frame_err pulse; cmd_* keep the previous values; cmd_valid=0;
//     busy=0 afterward.
//  3. Bytes 00 FF A5 02 ... with din_byte_rdy held high for 4 clk per byte -> leading 00/FF ignored;
//     each byte accepted once; frame decodes.
//  4. A5 01 then a gap of TIMEOUT_CYC clk -> frame_err at exactly TIMEOUT_CYC cycles; next
//     A5 03 00 00 05 06 decodes.
//  5. Accept coincident with the timeout cycle -> no frame_err; the byte is stored; the frame
//     completes normally.
//  6. rst asserted after the ADDR byte -> outputs 0 with no pulse; the remaining bytes 12 34 37
//     are ignored until a new A5.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command frame parser: FSM states, sync marker,
// TDC command codes and the frame checksum helper.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DHI  = 3'd3,
    ST_DLO  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Command codes understood by the TDC register block
  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_STOP  = 8'h04;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_frame_timeout.sv
// Inter-byte gap counter: hit is raised in the TIMEOUT_CYC-th enabled cycle after a clear.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [TO_W-1:0] count;

  assign hit = en && (count == TO_W'(TIMEOUT_CYC - 1));

  // Cycle counter, cleared on demand, advancing while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte SYNC/CMD/ADDR/DATA_HI/DATA_LO/CSUM frames from a UART byte stream and
// emits one-cycle cmd_valid or frame_err strobes with registered command fields.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din_byte,
  input  logic        din_byte_rdy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_err,
  output logic        busy
);

  state_t     state, state_n;
  logic       rdy_q;
  logic       accept;
  logic       to_clr, to_hit;
  logic [7:0] cmd_r, addr_r, dhi_r, dlo_r, csum_r, csum_n;
  logic       valid_n, err_n;

  // One accept per high period of the receiver's ready level
  assign accept = din_byte_rdy && !rdy_q;
  assign to_clr = accept || (state == ST_IDLE);

  frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .en  (!to_clr),
    .hit (to_hit)
  );

  // Next-state, checksum and strobe decode; an accept takes priority over a timeout
  always_comb begin
    state_n = state;
    csum_n  = csum_r;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (din_byte == SYNC_BYTE) begin
            state_n = ST_CMD;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_CMD: begin
          state_n = ST_ADDR;
          csum_n  = din_byte;
        end
        ST_ADDR: begin
          state_n = ST_DHI;
          csum_n  = csum_add(csum_r, din_byte);
        end
        ST_DHI: begin
          state_n = ST_DLO;
          csum_n  = csum_add(csum_r, din_byte);
        end
        ST_DLO: begin
          state_n = ST_CSUM;
          csum_n  = csum_add(csum_r, din_byte);
        end
        ST_CSUM: begin
          state_n = ST_IDLE;
          if (din_byte == csum_r) begin
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else if (to_hit) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
    end else begin
      state_n = state;
    end
  end

  // State, edge detector and checksum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rdy_q  <= 1'b0;
      csum_r <= 8'h00;
    end else begin
      state  <= state_n;
      rdy_q  <= din_byte_rdy;
      csum_r <= csum_n;
    end
  end

  // Partial-frame field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r  <= 8'h00;
      addr_r <= 8'h00;
      dhi_r  <= 8'h00;
      dlo_r  <= 8'h00;
    end else if (accept) begin
      case (state)
        ST_CMD:  cmd_r  <= din_byte;
        ST_ADDR: addr_r <= din_byte;
        ST_DHI:  dhi_r  <= din_byte;
        ST_DLO:  dlo_r  <= din_byte;
        default: cmd_r  <= cmd_r;
      endcase
    end else begin
      cmd_r <= cmd_r;
    end
  end

  // Registered outputs; command fields only change on a good frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      cmd_code  <= 8'h00;
      cmd_addr  <= 8'h00;
      cmd_data  <= 16'h0000;
    end else begin
      cmd_valid <= valid_n;
      frame_err <= err_n;
      busy      <= (state_n != ST_IDLE);
      if (valid_n) begin
        cmd_code <= cmd_r;
        cmd_addr <= addr_r;
        cmd_data <= {dhi_r, dlo_r};
      end else begin
        cmd_code <= cmd_code;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser with a shortened inter-byte timeout.
module tb_uart_cmd_parser;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_byte;
  logic        din_byte_rdy;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0;
  int at_cyc;
  logic found;

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (T),
    .TO_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din_byte     (din_byte),
    .din_byte_rdy (din_byte_rdy),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (cmd_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    din_byte = b;
    din_byte_rdy = 1'b1;
    repeat (hold) @(negedge clk);
    din_byte_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din_byte = 8'h00;
    din_byte_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fields", {cmd_code, cmd_addr, cmd_data}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: good frame
    v0 = valid_cnt; e0 = err_cnt;
    send(8'hA5, 1); send(8'h01, 1); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    send(8'h37, 1);
    check("t1_valid", {31'd0, cmd_valid}, 32'd1);
    check("t1_fields", {cmd_code, cmd_addr, cmd_data}, 32'h0110_1234);
    @(negedge clk);
    check("t1_valid_1cyc", {31'd0, cmd_valid}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_npulse", valid_cnt - v0, 32'd1);
    check("t1_noerr", err_cnt - e0, 32'd0);

    // 2: bad checksum
    v0 = valid_cnt; e0 = err_cnt;
    send(8'hA5, 1); send(8'h01, 1); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1);
    send(8'h36, 1);
    check("t2_err", {31'd0, frame_err}, 32'd1);
    check("t2_novalid", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("t2_err_1cyc", {31'd0, frame_err}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_fields_kept", {cmd_code, cmd_addr, cmd_data}, 32'h0110_1234);
    check("t2_counts", {err_cnt - e0, valid_cnt - v0}, {32'd1, 32'd0});

    // 3: long ready level, leading junk
    v0 = valid_cnt; e0 = err_cnt;
    send(8'h00, 4); send(8'hFF, 4);
    check("t3_junk_idle", {31'd0, busy}, 32'd0);
    send(8'hA5, 4); send(8'h02, 4); send(8'h44, 4); send(8'h56, 4); send(8'h78, 4);
    send(8'h68, 4);
    @(negedge clk);
    check("t3_fields", {cmd_code, cmd_addr, cmd_data}, 32'h0244_5678);
    check("t3_npulse", valid_cnt - v0, 32'd1);
    check("t3_noerr", err_cnt - e0, 32'd0);

    // 4: inter-byte timeout
    e0 = err_cnt;
    send(8'hA5, 1); send(8'h01, 1);
    found = 1'b0;
    at_cyc = 0;
    for (int k = 1; k <= T + 20 && !found; k++) begin
      @(negedge clk);
      if (frame_err) begin
        found = 1'b1;
        at_cyc = k;
      end
    end
    check("t4_timeout_seen", {31'd0, found}, 32'd1);
    check("t4_timeout_cyc", at_cyc, T);
    @(negedge clk);
    check("t4_busy", {31'd0, busy}, 32'd0);
    v0 = valid_cnt;
    send(8'hA5, 1); send(8'h03, 1); send(8'h00, 1); send(8'h00, 1); send(8'h05, 1);
    send(8'h06, 1);
    check("t4_next_frame", {cmd_code, cmd_addr, cmd_data}, 32'h0300_0005);
    @(negedge clk);
    check("t4_counts", {err_cnt - e0, valid_cnt - v0}, {32'd1, 32'd1});

    // 5: accept in the same cycle the timeout would fire
    v0 = valid_cnt; e0 = err_cnt;
    send(8'hA5, 1); send(8'h07, 1);
    repeat (T - 2) @(negedge clk);
    send(8'h22, 1);
    send(8'hAB, 1); send(8'hCD, 1); send(8'h43, 1);
    check("t5_fields", {cmd_code, cmd_addr, cmd_data}, 32'h0722_ABCD);
    @(negedge clk);
    check("t5_counts", {err_cnt - e0, valid_cnt - v0}, {32'd0, 32'd1});

    // SYNC inside a frame is plain data
    send(8'hA5, 1); send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    send(8'hA5, 1);
    check("sync_as_data", {cmd_code, cmd_addr, cmd_data}, 32'hA501_0203);

    // 6: reset mid-frame
    send(8'hA5, 1); send(8'h01, 1); send(8'h10, 1);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    v0 = valid_cnt; e0 = err_cnt;
    rst = 1'b1;
    #1;
    check("t6_rst_fields", {cmd_code, cmd_addr, cmd_data}, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h12, 1); send(8'h34, 1); send(8'h37, 1);
    @(negedge clk);
    check("t6_ignored_busy", {31'd0, busy}, 32'd0);
    check("t6_ignored_counts", {err_cnt - e0, valid_cnt - v0}, {32'd0, 32'd0});
    send(8'hA5, 1); send(8'h01, 1); send(8'h10, 1); send(8'h12, 1); send(8'h34, 1);
    send(8'h37, 1);
    check("t6_recover", {cmd_code, cmd_addr, cmd_data}, 32'h0110_1234);
    @(negedge clk);
    check("t6_recover_pulse", valid_cnt - v0, 32'd1);

    check("never_both", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
